// File: rtl/instruction_fetch.sv
// Instruction fetch unit: holds the PC, requests 64-bit lines from a fixed-latency
// instruction memory, buffers one line and hands 16-bit instructions to decode.
module instruction_fetch #(
    parameter int unsigned LATENCY  = 5,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] mem_addr,
    input  logic [63:0] mem_ins,
    output logic [15:0] if_ins,
    output logic [15:0] if_pc,
    output logic        if_valid,
    input  logic        id_stall,
    input  logic        br_taken,
    input  logic [15:0] br_target,
    output logic [15:0] fill_count,
    output logic        dbg_state
);

    localparam int unsigned     CNT_W    = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY);
    localparam logic [15:0]     PC_RST   = RESET_PC & 16'hFFFE;
    // Reset address deliberately points at a different line than the first
    // request so the memory always sees an address change and restarts.
    localparam logic [15:0]     ADDR_RST = {RESET_PC[15:3] ^ 13'h1, 3'b000};

    typedef enum logic {
        S_HIT  = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_d;
    logic [15:1]      pc_q;
    logic [15:1]      pc_d;
    logic [15:3]      addr_q;
    logic [15:3]      addr_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic [63:0]      line_buf;
    logic [15:3]      buf_tag;
    logic             buf_valid;
    logic             capture;
    logic             hit;
    logic [15:3]      tgt_line;
    logic             unused_bits;

    assign tgt_line    = br_target[15:3];
    assign unused_bits = br_target[0];
    assign capture     = (state == S_WAIT) && (cnt == CNT_LAST);

    // Handshake: an instruction is transferred to decode on every cycle with
    // if_valid=1 and id_stall=0; with id_stall=1 if_ins/if_pc hold steady.
    // br_taken overrides both and the PC jumps to br_target.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_HIT;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            S_HIT:   if (!br_taken && !hit) state_d = S_WAIT;
            S_WAIT:  if (capture) state_d = S_HIT;
            default: state_d = S_HIT;
        endcase
    end

    always_comb begin
        hit       = (state == S_HIT) && buf_valid && (buf_tag == pc_q[15:3]);
        if_valid  = hit;
        if_pc     = {pc_q, 1'b0};
        if_ins    = line_buf[{pc_q[2:1], 4'b0000} +: 16];
        mem_addr  = {addr_q, 3'b000};
        dbg_state = state;
    end

    always_comb begin
        pc_d   = pc_q;
        addr_d = addr_q;
        cnt_d  = cnt;
        case (state)
            S_HIT: begin
                if (br_taken) begin
                    pc_d = br_target[15:1];
                end else if (hit) begin
                    if (!id_stall) pc_d = pc_q + 15'd1;
                end else begin
                    addr_d = pc_q[15:3];
                    cnt_d  = '0;
                end
            end
            S_WAIT: begin
                if (br_taken) pc_d = br_target[15:1];
                if (capture) begin
                    cnt_d = '0;
                end else if (br_taken && (tgt_line != addr_q)) begin
                    // Abandon the in-flight line; the memory restarts on the new address.
                    addr_d = tgt_line;
                    cnt_d  = '0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q       <= PC_RST[15:1];
            addr_q     <= ADDR_RST[15:3];
            cnt        <= '0;
            line_buf   <= '0;
            buf_tag    <= '0;
            buf_valid  <= 1'b0;
            fill_count <= '0;
        end else begin
            pc_q   <= pc_d;
            addr_q <= addr_d;
            cnt    <= cnt_d;
            if (capture) begin
                line_buf  <= mem_ins;
                buf_tag   <= addr_q;
                buf_valid <= 1'b1;
                if (fill_count != 16'hFFFF) fill_count <= fill_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: fixed-latency memory model with halfword i = i,
// a deadline-based reference model checked every cycle, and directed scenarios.
module tb_instruction_fetch;

    localparam int          LAT    = 5;
    localparam logic [15:0] RST_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] mem_addr;
    logic [63:0] mem_ins;
    logic [15:0] if_ins;
    logic [15:0] if_pc;
    logic        if_valid;
    logic        id_stall = 1'b0;
    logic        br_taken = 1'b0;
    logic [15:0] br_target = 16'h0000;
    logic [15:0] fill_count;
    logic        dbg_state;

    int errors = 0;
    int checks = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    instruction_fetch #(.LATENCY(LAT), .RESET_PC(RST_PC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_addr   (mem_addr),
        .mem_ins    (mem_ins),
        .if_ins     (if_ins),
        .if_pc      (if_pc),
        .if_valid   (if_valid),
        .id_stall   (id_stall),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .fill_count (fill_count),
        .dbg_state  (dbg_state)
    );

    // ---------------- memory model ----------------
    // Sees an address one edge after it changes; data is good LAT edges later.
    logic [15:0] seen_addr = 16'hFFFF;
    int          age = 0;

    function automatic logic [63:0] line_data(input logic [15:0] a);
        logic [63:0] d;
        for (int k = 0; k < 4; k++) d[16*k +: 16] = (a >> 1) + 16'(k);
        return d;
    endfunction

    always @(posedge clk) begin
        if (mem_addr != seen_addr) begin
            seen_addr <= mem_addr;
            age       <= 0;
        end else if (age < 1000) begin
            age <= age + 1;
        end
    end

    always_comb begin
        if (mem_addr == seen_addr && age >= LAT - 1) mem_ins = line_data(mem_addr);
        else                                         mem_ins = 64'hDEAD_BEEF_DEAD_BEEF;
    end

    // ---------------- reference model ----------------
    logic        m_live = 1'b0;
    logic [15:0] m_pc;
    logic        m_buf_ok;
    logic [15:0] m_buf_line;
    logic        m_pend;
    logic [15:0] m_addr;
    int          m_done;
    logic [15:0] m_fills;
    logic        m_v;
    int          n = 0;

    function automatic logic model_valid();
        return m_live && !m_pend && m_buf_ok && (m_buf_line == (m_pc & 16'hFFF8));
    endfunction

    always @(posedge clk) begin
        n = n + 1;
        if (!rst_n) begin
            m_live   = 1'b1;
            m_pc     = RST_PC & 16'hFFFE;
            m_buf_ok = 1'b0;
            m_buf_line = 16'h0000;
            m_pend   = 1'b0;
            m_fills  = 16'h0000;
            m_addr   = {RST_PC[15:3] ^ 13'h1, 3'b000};
            m_done   = 0;
        end else if (m_live) begin
            if (m_pend) begin
                if (n == m_done) begin
                    m_buf_ok   = 1'b1;
                    m_buf_line = m_addr;
                    m_pend     = 1'b0;
                    if (m_fills != 16'hFFFF) m_fills = m_fills + 16'd1;
                    if (br_taken) m_pc = br_target & 16'hFFFE;
                end else if (br_taken) begin
                    m_pc = br_target & 16'hFFFE;
                    if ((m_pc & 16'hFFF8) != m_addr) begin
                        m_addr = m_pc & 16'hFFF8;
                        m_done = n + LAT + 1;
                    end
                end
            end else begin
                m_v = model_valid();
                if (br_taken)             m_pc = br_target & 16'hFFFE;
                else if (m_v && !id_stall) m_pc = m_pc + 16'd2;
                else if (!m_v) begin
                    m_pend = 1'b1;
                    m_addr = m_pc & 16'hFFF8;
                    m_done = n + LAT + 1;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_live) begin
            check("cmp_valid", 64'(if_valid), 64'(model_valid()));
            check("cmp_fill", 64'(fill_count), 64'(m_fills));
            check("cmp_addr", 64'(mem_addr), 64'(m_addr));
            if (model_valid()) begin
                check("cmp_pc", 64'(if_pc), 64'(m_pc));
                check("cmp_ins", 64'(if_ins), 64'(m_pc >> 1));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        br_taken = 1'b0;
        id_stall = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic expect_out(input string name, input logic v, input logic [15:0] pc,
                              input logic [15:0] ins);
        check({name, "_valid"}, 64'(if_valid), 64'(v));
        if (v) begin
            check({name, "_pc"}, 64'(if_pc), 64'(pc));
            check({name, "_ins"}, 64'(if_ins), 64'(ins));
        end
    endtask

    task automatic expect_idle(input string name, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            tick();
            check(name, 64'(if_valid), 64'd0);
        end
    endtask

    // Mixed stall/branch vectors, checked only by the reference model
    logic [16:0] vec [0:15];
    logic        vstall [0:15];

    initial begin
        vec[0]  = {1'b0, 16'h0000}; vstall[0]  = 1'b1;
        vec[1]  = {1'b0, 16'h0000}; vstall[1]  = 1'b0;
        vec[2]  = {1'b1, 16'h0125}; vstall[2]  = 1'b1;
        vec[3]  = {1'b0, 16'h0000}; vstall[3]  = 1'b0;
        vec[4]  = {1'b1, 16'h0127}; vstall[4]  = 1'b0;
        vec[5]  = {1'b0, 16'h0000}; vstall[5]  = 1'b1;
        vec[6]  = {1'b1, 16'h0200}; vstall[6]  = 1'b0;
        vec[7]  = {1'b0, 16'h0000}; vstall[7]  = 1'b0;
        vec[8]  = {1'b0, 16'h0000}; vstall[8]  = 1'b1;
        vec[9]  = {1'b1, 16'h0202}; vstall[9]  = 1'b0;
        vec[10] = {1'b0, 16'h0000}; vstall[10] = 1'b0;
        vec[11] = {1'b0, 16'h0000}; vstall[11] = 1'b0;
        vec[12] = {1'b0, 16'h0000}; vstall[12] = 1'b1;
        vec[13] = {1'b1, 16'h0009}; vstall[13] = 1'b0;
        vec[14] = {1'b0, 16'h0000}; vstall[14] = 1'b0;
        vec[15] = {1'b0, 16'h0000}; vstall[15] = 1'b0;
    end

    // ---------------- directed scenarios ----------------
    initial begin
        // A: reset, sequential fetch, stall, second line fill
        do_reset();
        check("rst_valid", 64'(if_valid), 64'd0);
        check("rst_fill", 64'(fill_count), 64'd0);
        check("rst_addr", 64'(mem_addr), 64'h0008);
        expect_idle("a_boot_idle", 6);
        tick(); expect_out("a_first", 1'b1, 16'h0000, 16'h0000);
        tick(); expect_out("a_second", 1'b1, 16'h0002, 16'h0001);
        id_stall = 1'b1;
        repeat (3) begin
            tick(); expect_out("a_stall", 1'b1, 16'h0002, 16'h0001);
        end
        id_stall = 1'b0;
        tick(); expect_out("a_release", 1'b1, 16'h0004, 16'h0002);
        tick(); expect_out("a_last", 1'b1, 16'h0006, 16'h0003);
        expect_idle("a_miss_idle", 7);
        tick(); expect_out("a_line8", 1'b1, 16'h0008, 16'h0004);
        check("a_fill", 64'(fill_count), 64'd2);

        // B: redirect in HIT to an odd target in another line
        do_reset();
        repeat (7) tick();
        expect_out("b_start", 1'b1, 16'h0000, 16'h0000);
        br_taken = 1'b1; br_target = 16'h0031;
        tick();
        br_taken = 1'b0;
        check("b_pc", 64'(if_pc), 64'h0030);
        check("b_valid", 64'(if_valid), 64'd0);
        tick();
        check("b_addr", 64'(mem_addr), 64'h0030);
        expect_idle("b_idle", 5);
        tick(); expect_out("b_hit", 1'b1, 16'h0030, 16'h0018);
        check("b_fill", 64'(fill_count), 64'd2);

        // C: redirect to another line in the 3rd WAIT cycle of the fill for 0x0008
        do_reset();
        repeat (7) tick();
        repeat (4) tick();
        check("c_miss_valid", 64'(if_valid), 64'd0);
        tick();
        check("c_addr8", 64'(mem_addr), 64'h0008);
        repeat (2) tick();
        br_taken = 1'b1; br_target = 16'h0040;
        tick();
        br_taken = 1'b0;
        check("c_addr40", 64'(mem_addr), 64'h0040);
        check("c_pc40", 64'(if_pc), 64'h0040);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("c_idle", 64'(if_valid), 64'd0);
            check("c_nofill", 64'(fill_count), 64'd1);
        end
        tick(); expect_out("c_hit", 1'b1, 16'h0040, 16'h0020);
        check("c_fill", 64'(fill_count), 64'd2);

        // E: reset asserted for one edge in the middle of a WAIT
        br_taken = 1'b1; br_target = 16'h0080;
        tick();
        br_taken = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("e_valid", 64'(if_valid), 64'd0);
        check("e_fill", 64'(fill_count), 64'd0);
        check("e_addr", 64'(mem_addr), 64'h0008);
        expect_idle("e_idle", 6);
        tick(); expect_out("e_first", 1'b1, 16'h0000, 16'h0000);

        // F: PC wrap from 0xFFFE to 0x0000
        br_taken = 1'b1; br_target = 16'hFFFC;
        tick();
        br_taken = 1'b0;
        expect_idle("f_idle", 6);
        tick(); expect_out("f_fffc", 1'b1, 16'hFFFC, 16'h7FFE);
        tick(); expect_out("f_fffe", 1'b1, 16'hFFFE, 16'h7FFF);
        tick();
        check("f_wrap_pc", 64'(if_pc), 64'h0000);
        check("f_wrap_valid", 64'(if_valid), 64'd0);
        expect_idle("f_idle2", 6);
        tick(); expect_out("f_back", 1'b1, 16'h0000, 16'h0000);

        // D: redirect on the capture edge into the captured line
        do_reset();
        repeat (6) tick();
        br_taken = 1'b1; br_target = 16'h0006;
        tick();
        br_taken = 1'b0;
        expect_out("d_cap", 1'b1, 16'h0006, 16'h0003);
        check("d_fill", 64'(fill_count), 64'd1);
        tick();
        check("d_next_pc", 64'(if_pc), 64'h0008);
        check("d_fill2", 64'(fill_count), 64'd1);
        check("d_addr", 64'(mem_addr), 64'h0000);

        // Mixed vectors, compared against the reference model every cycle
        repeat (8) tick();
        for (int i = 0; i < 16; i++) begin
            br_taken  = vec[i][16];
            br_target = vec[i][15:0];
            id_stall  = vstall[i];
            repeat (3) tick();
        end
        br_taken = 1'b0;
        id_stall = 1'b0;
        repeat (12) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
